mem_arbiter: RTL

Sequential arbiter that shares the single RAM port between the instruction cache and data cache of one core. Sits between the `caches` block's cache-control side and the RAM model. It serialises one word transaction at a time, gives the data side priority, and bounds instruction-side starvation. Responses return on a registered, one-cycle handshake.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_stats.sv | 35 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory arbiter.
package mem_arb_pkg;

    localparam int STARVE_W = 4;
    localparam int STAT_W   = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4
    } arb_state_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating performance counters for the memory arbiter (grants and stall cycles).
module mem_arb_stats
    import mem_arb_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              igrant_inc,
    input  logic              dgrant_inc,
    input  logic              stall_inc,
    output logic [STAT_W-1:0] stat_igrant,
    output logic [STAT_W-1:0] stat_dgrant,
    output logic [STAT_W-1:0] stat_stall
);

    logic [2:0]             inc;
    logic [2:0][STAT_W-1:0] cnt_q, cnt_d;

    assign inc = {stall_inc, dgrant_inc, igrant_inc};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = (inc[i] && !(&cnt_q[i])) ? cnt_q[i] + 1'b1 : cnt_q[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign stat_igrant = cnt_q[0];
    assign stat_dgrant = cnt_q[1];
    assign stat_stall  = cnt_q[2];

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache word accesses onto one RAM port; data side has priority
// with bounded instruction starvation. Define MEM_ARB_STATS_EN to enable the stat counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int WORD_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [STAT_W-1:0] stat_igrant,
    output logic [STAT_W-1:0] stat_dgrant,
    output logic [STAT_W-1:0] stat_stall
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                ren_q, ren_d, wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   store_q, store_d;
    logic [WORD_W-1:0]   iload_q, iload_d, dload_q, dload_d;
    logic                d_pend, ram_ack, in_grant;
    ramstate_t           rs;

    assign d_pend   = dREN | dWEN;
    assign rs       = ramstate_t'(ramstate);
    assign ram_ack  = (rs == ACCESS);
    assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_pend && (!iREN || starve_q < LIMIT)) state_d = GRANT_D;
                else if (iREN)                             state_d = GRANT_I;
            end
            // BUSY/FREE/ERROR all hold; the strobes stay up so ERROR is simply reissued
            GRANT_I: if (ram_ack) state_d = DONE_I;
            GRANT_D: if (ram_ack) state_d = DONE_D;
            DONE_I,
            DONE_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        store_d  = store_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        if (state_q == IDLE) begin
            if (!iREN) starve_d = '0;
            if (state_d == GRANT_D) begin
                addr_d  = daddr;
                store_d = dstore;
                wen_d   = dWEN;
                ren_d   = !dWEN;
                if (iREN) starve_d = starve_q + STARVE_W'(1);
            end else if (state_d == GRANT_I) begin
                addr_d   = iaddr;
                wen_d    = 1'b0;
                ren_d    = 1'b1;
                starve_d = '0;
            end
        end
        if (in_grant && ram_ack) begin
            ren_d = 1'b0;
            wen_d = 1'b0;
            if (state_q == GRANT_I) iload_d = ramload;
            else if (ren_q)         dload_d = ramload;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_q <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            iload_q  <= '0;
            dload_q  <= '0;
        end else begin
            starve_q <= starve_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
        end
    end

    always_comb begin
        iwait    = (state_q != DONE_I);
        dwait    = (state_q != DONE_D);
        ramREN   = ren_q;
        ramWEN   = wen_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        iload    = iload_q;
        dload    = dload_q;
    end

`ifdef MEM_ARB_STATS_EN
    logic stall;
    assign stall = (iREN && iwait) || (d_pend && dwait);

    mem_arb_stats u_stats (
        .CLK         (CLK),
        .RST         (RST),
        .igrant_inc  (state_q == IDLE && state_d == GRANT_I),
        .dgrant_inc  (state_q == IDLE && state_d == GRANT_D),
        .stall_inc   (stall),
        .stat_igrant (stat_igrant),
        .stat_dgrant (stat_dgrant),
        .stat_stall  (stat_stall)
    );
`else
    assign stat_igrant = '0;
    assign stat_dgrant = '0;
    assign stat_stall  = '0;
`endif

endmodule
